// File: rtl/prbs4_checker.sv
`timescale 1ns/1ps
// prbs4_checker: self-synchronising checker for the x^4+x^3+1 serial PRBS.
// It locks onto the incoming stream, then compares every bit against a
// free-running local copy of the generator and counts mismatches.
module prbs4_checker #(
   parameter int unsigned LOCK_COUNT = 8,
   parameter int unsigned LOSS_COUNT = 3,
   parameter int unsigned CNT_W      = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             din,
   input  logic             din_valid,
   input  logic             clr_cnt,
   output logic             locked,
   output logic             err_pulse,
   output logic [CNT_W-1:0] err_count,
   output logic [CNT_W-1:0] bit_count
);

   localparam int unsigned      RUN_W    = 8;
   localparam logic [RUN_W-1:0] LOCK_TGT = RUN_W'(LOCK_COUNT);
   localparam logic [RUN_W-1:0] LOSS_TGT = RUN_W'(LOSS_COUNT);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;

   typedef enum logic {SEARCH, LOCKED} state_t;

   state_t           state;
   logic [3:0]       h;
   logic [2:0]       fill;
   logic [RUN_W-1:0] match_cnt;
   logic [RUN_W-1:0] miss_cnt;

   logic pred_c;
   logic miss_c;
   logic bit_inc_c;
   logic err_inc_c;

   // Next expected bit from the history, and per-bit count enables.
   assign pred_c    = h[3] ^ h[2];
   assign miss_c    = (din != pred_c);
   assign bit_inc_c = din_valid && (state == LOCKED);
   assign err_inc_c = bit_inc_c && miss_c;

   // Lock/loss state machine with history register; invalid cycles freeze it.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= SEARCH;
         h         <= 4'h0;
         fill      <= 3'd0;
         match_cnt <= '0;
         miss_cnt  <= '0;
         locked    <= 1'b0;
         err_pulse <= 1'b0;
      end else begin
         err_pulse <= 1'b0;
         if (din_valid) begin
            if (state == SEARCH) begin
               h <= {h[2:0], din};
               if (fill != 3'd4) begin
                  fill <= fill + 3'd1;
               end else if ((h != 4'h0) && !miss_c) begin
                  // The zero history is never a valid generator state, so it cannot match.
                  if (match_cnt == LOCK_TGT - RUN_W'(1)) begin
                     state     <= LOCKED;
                     locked    <= 1'b1;
                     match_cnt <= '0;
                     miss_cnt  <= '0;
                  end else begin
                     match_cnt <= match_cnt + RUN_W'(1);
                  end
               end else begin
                  match_cnt <= '0;
               end
            end else begin
               // Reference runs free: received bits never enter the history,
               // so one flipped bit yields exactly one error.
               h <= {h[2:0], pred_c};
               if (miss_c) begin
                  err_pulse <= 1'b1;
                  if (miss_cnt == LOSS_TGT - RUN_W'(1)) begin
                     state     <= SEARCH;
                     locked    <= 1'b0;
                     fill      <= 3'd0;
                     match_cnt <= '0;
                     miss_cnt  <= '0;
                  end else begin
                     miss_cnt <= miss_cnt + RUN_W'(1);
                  end
               end else begin
                  miss_cnt <= '0;
               end
            end
         end
      end
   end

   // Saturating error/bit counters; clear loads zero plus this cycle's increment.
   always_ff @(posedge clk) begin
      if (reset) begin
         err_count <= '0;
         bit_count <= '0;
      end else begin
         if (clr_cnt) begin
            err_count <= CNT_W'(err_inc_c);
         end else if (err_inc_c && (err_count != CNT_MAX)) begin
            err_count <= err_count + CNT_W'(1);
         end

         if (clr_cnt) begin
            bit_count <= CNT_W'(bit_inc_c);
         end else if (bit_inc_c && (bit_count != CNT_MAX)) begin
            bit_count <= bit_count + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_prbs4_checker.sv
`timescale 1ns/1ps
// Directed bench for prbs4_checker: default instance plus a narrow-counter,
// long-loss instance for saturation. Both share the same stimulus.
module tb_prbs4_checker;

   localparam int unsigned CNT_W = 16;
   localparam int unsigned SAT_W = 4;

   logic             clk = 1'b0;
   logic             reset;
   logic             din;
   logic             din_valid;
   logic             clr_cnt;
   logic             locked;
   logic             err_pulse;
   logic [CNT_W-1:0] err_count;
   logic [CNT_W-1:0] bit_count;
   logic             s_locked;
   logic             s_err_pulse;
   logic [SAT_W-1:0] s_err_count;
   logic [SAT_W-1:0] s_bit_count;

   int         checks = 0;
   int         fails  = 0;
   logic [3:0] gs;

   prbs4_checker #(.LOCK_COUNT(8), .LOSS_COUNT(3), .CNT_W(CNT_W)) dut (
      .clk(clk), .reset(reset), .din(din), .din_valid(din_valid), .clr_cnt(clr_cnt),
      .locked(locked), .err_pulse(err_pulse), .err_count(err_count), .bit_count(bit_count)
   );

   prbs4_checker #(.LOCK_COUNT(8), .LOSS_COUNT(255), .CNT_W(SAT_W)) dut_sat (
      .clk(clk), .reset(reset), .din(din), .din_valid(din_valid), .clr_cnt(clr_cnt),
      .locked(s_locked), .err_pulse(s_err_pulse), .err_count(s_err_count), .bit_count(s_bit_count)
   );

   always #5 clk = ~clk;

   // Apply one cycle of input, then sample 1 ns after the edge.
   task automatic step(input logic d, input logic v, input logic c);
      din = d; din_valid = v; clr_cnt = c;
      @(posedge clk); #1;
      din_valid = 1'b0; clr_cnt = 1'b0;
   endtask

   // Reference generator, seeded 4'hF on reset.
   task automatic gen(output logic b);
      b  = gs[3] ^ gs[2];
      gs = {gs[2:0], b};
   endtask

   task automatic do_reset();
      reset = 1'b1; din = 1'b0; din_valid = 1'b0; clr_cnt = 1'b0;
      @(posedge clk); #1;
      reset = 1'b0;
      gs = 4'hF;
   endtask

   task automatic send_clean(input int n, output int pulses);
      logic b;
      pulses = 0;
      for (int i = 0; i < n; i++) begin
         gen(b);
         step(b, 1'b1, 1'b0);
         if (err_pulse) pulses++;
      end
   endtask

   task automatic send_flip(input logic c);
      logic b;
      gen(b);
      step(~b, 1'b1, c);
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if (locked !== 1'b0) begin fails++; $display("FAIL reset_locked: got %0d want 0", locked); end
      checks++; if (err_pulse !== 1'b0) begin fails++; $display("FAIL reset_err_pulse: got %0d want 0", err_pulse); end
      checks++; if (err_count !== 16'd0) begin fails++; $display("FAIL reset_err_count: got %0d want 0", err_count); end
      checks++; if (bit_count !== 16'd0) begin fails++; $display("FAIL reset_bit_count: got %0d want 0", bit_count); end
   endtask

   task automatic test_lock();
      int p1, p2, p3;
      do_reset();
      send_clean(11, p1);
      checks++; if (locked !== 1'b0) begin fails++; $display("FAIL lock_early: got %0d want 0 after bit 11", locked); end
      send_clean(1, p2);
      checks++; if (locked !== 1'b1) begin fails++; $display("FAIL lock_bit12: got %0d want 1", locked); end
      checks++; if (bit_count !== 16'd0) begin fails++; $display("FAIL lock_bitcnt0: got %0d want 0", bit_count); end
      send_clean(5, p3);
      checks++; if (bit_count !== 16'd5) begin fails++; $display("FAIL lock_bitcnt5: got %0d want 5", bit_count); end
      checks++; if (err_count !== 16'd0) begin fails++; $display("FAIL lock_errcnt: got %0d want 0", err_count); end
      checks++; if (p1 + p2 + p3 !== 0) begin fails++; $display("FAIL lock_pulses: got %0d want 0", p1 + p2 + p3); end
   endtask

   task automatic test_single_flip();
      int p;
      send_flip(1'b0);
      checks++; if (err_pulse !== 1'b1) begin fails++; $display("FAIL flip_pulse: got %0d want 1", err_pulse); end
      checks++; if (err_count !== 16'd1) begin fails++; $display("FAIL flip_errcnt: got %0d want 1", err_count); end
      checks++; if (locked !== 1'b1) begin fails++; $display("FAIL flip_locked: got %0d want 1", locked); end
      send_clean(10, p);
      checks++; if (p !== 0) begin fails++; $display("FAIL flip_after_pulses: got %0d want 0", p); end
      checks++; if (err_count !== 16'd1) begin fails++; $display("FAIL flip_after_errcnt: got %0d want 1", err_count); end
      checks++; if (bit_count !== 16'd16) begin fails++; $display("FAIL flip_after_bitcnt: got %0d want 16", bit_count); end
      checks++; if (locked !== 1'b1) begin fails++; $display("FAIL flip_after_locked: got %0d want 1", locked); end
   endtask

   task automatic test_burst_loss();
      int p;
      do_reset();
      send_clean(12, p);
      checks++; if (locked !== 1'b1) begin fails++; $display("FAIL burst_prelock: got %0d want 1", locked); end
      for (int i = 0; i < 3; i++) begin
         send_flip(1'b0);
         checks++; if (err_pulse !== 1'b1) begin fails++; $display("FAIL burst_pulse%0d: got %0d want 1", i, err_pulse); end
         checks++; if (locked !== (i < 2)) begin fails++; $display("FAIL burst_locked%0d: got %0d want %0d", i, locked, (i < 2)); end
      end
      checks++; if (err_count !== 16'd3) begin fails++; $display("FAIL burst_errcnt: got %0d want 3", err_count); end
      checks++; if (bit_count !== 16'd3) begin fails++; $display("FAIL burst_bitcnt: got %0d want 3", bit_count); end
      send_clean(11, p);
      checks++; if (locked !== 1'b0) begin fails++; $display("FAIL relock_early: got %0d want 0", locked); end
      send_clean(1, p);
      checks++; if (locked !== 1'b1) begin fails++; $display("FAIL relock: got %0d want 1", locked); end
      checks++; if (err_count !== 16'd3) begin fails++; $display("FAIL relock_errcnt_held: got %0d want 3", err_count); end
   endtask

   task automatic test_zero();
      int seen_lock = 0;
      int seen_pulse = 0;
      do_reset();
      for (int i = 0; i < 100; i++) begin
         step(1'b0, 1'b1, 1'b0);
         if (locked) seen_lock++;
         if (err_pulse) seen_pulse++;
      end
      checks++; if (seen_lock !== 0) begin fails++; $display("FAIL zero_locked: got %0d locked cycles want 0", seen_lock); end
      checks++; if (seen_pulse !== 0) begin fails++; $display("FAIL zero_pulses: got %0d want 0", seen_pulse); end
      checks++; if (err_count !== 16'd0) begin fails++; $display("FAIL zero_errcnt: got %0d want 0", err_count); end
   endtask

   task automatic test_gaps();
      int   nv = 0;
      int   seen_pulse = 0;
      int   p;
      logic b;
      do_reset();
      while (nv < 12) begin
         if ($urandom_range(0, 2) == 0) begin
            step(1'($urandom_range(0, 1)), 1'b0, 1'b0);
            if (err_pulse) seen_pulse++;
         end else begin
            gen(b);
            step(b, 1'b1, 1'b0);
            nv++;
            if (err_pulse) seen_pulse++;
            if (nv == 11) begin
               checks++; if (locked !== 1'b0) begin fails++; $display("FAIL gap_early: got %0d want 0", locked); end
            end
         end
      end
      checks++; if (locked !== 1'b1) begin fails++; $display("FAIL gap_lock: got %0d want 1", locked); end
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0);
      checks++; if (bit_count !== 16'd0) begin fails++; $display("FAIL gap_freeze_bitcnt: got %0d want 0", bit_count); end
      send_clean(4, p);
      checks++; if (seen_pulse + p !== 0) begin fails++; $display("FAIL gap_pulses: got %0d want 0", seen_pulse + p); end
      checks++; if (bit_count !== 16'd4) begin fails++; $display("FAIL gap_bitcnt: got %0d want 4", bit_count); end
      send_flip(1'b1);
      checks++; if (err_count !== 16'd1) begin fails++; $display("FAIL clr_err_errcnt: got %0d want 1", err_count); end
      checks++; if (bit_count !== 16'd1) begin fails++; $display("FAIL clr_err_bitcnt: got %0d want 1", bit_count); end
      checks++; if (err_pulse !== 1'b1) begin fails++; $display("FAIL clr_err_pulse: got %0d want 1", err_pulse); end
      step(1'b0, 1'b0, 1'b0);
      checks++; if (err_pulse !== 1'b0) begin fails++; $display("FAIL gap_pulse_low: got %0d want 0", err_pulse); end
   endtask

   task automatic test_saturation();
      int p;
      do_reset();
      send_clean(12, p);
      checks++; if (s_locked !== 1'b1) begin fails++; $display("FAIL sat_lock: got %0d want 1", s_locked); end
      for (int i = 0; i < 20; i++) send_flip(1'b0);
      checks++; if (s_err_count !== 4'd15) begin fails++; $display("FAIL sat_errcnt: got %0d want 15", s_err_count); end
      checks++; if (s_bit_count !== 4'd15) begin fails++; $display("FAIL sat_bitcnt: got %0d want 15", s_bit_count); end
      checks++; if (s_locked !== 1'b1) begin fails++; $display("FAIL sat_locked: got %0d want 1", s_locked); end
      send_flip(1'b1);
      checks++; if (s_err_count !== 4'd1) begin fails++; $display("FAIL sat_clr_errcnt: got %0d want 1", s_err_count); end
      checks++; if (s_bit_count !== 4'd1) begin fails++; $display("FAIL sat_clr_bitcnt: got %0d want 1", s_bit_count); end
      // Reset with a bad valid bit present: reset must win.
      reset = 1'b1; din = ~(gs[3] ^ gs[2]); din_valid = 1'b1; clr_cnt = 1'b0;
      @(posedge clk); #1;
      reset = 1'b0; din_valid = 1'b0;
      checks++; if (s_locked !== 1'b0) begin fails++; $display("FAIL rst_locked: got %0d want 0", s_locked); end
      checks++; if (s_err_pulse !== 1'b0) begin fails++; $display("FAIL rst_pulse: got %0d want 0", s_err_pulse); end
      checks++; if (s_err_count !== 4'd0) begin fails++; $display("FAIL rst_errcnt: got %0d want 0", s_err_count); end
      checks++; if (s_bit_count !== 4'd0) begin fails++; $display("FAIL rst_bitcnt: got %0d want 0", s_bit_count); end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; din = 1'b0; din_valid = 1'b0; clr_cnt = 1'b0; gs = 4'hF;
      test_reset();
      test_lock();
      test_single_flip();
      test_burst_loss();
      test_zero();
      test_gaps();
      test_saturation();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, fails);
      $finish;
   end

endmodule
